// File: rtl/ad7606_seq_ctrl.sv
// AD7606 parallel-mode conversion sequencer: reset pulse, periodic CONVST, BUSY wait, CS/RD burst.
// Optional FRSTDATA alignment check enabled by defining AD7606_FRSTDATA_CHK_EN.
module ad7606_seq_ctrl #(
  parameter int NCH      = 8,
  parameter int RST_CYC  = 5,
  parameter int CONV_LOW = 2,
  parameter int RD_LOW   = 2,
  parameter int RD_HIGH  = 2,
  parameter int PERIOD   = 2500,
  parameter int BUSY_TMO = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [2:0]  os_cfg,
  input  logic [15:0] ad_data,
  input  logic        ad_busy,
  input  logic        first_data,
  output logic [2:0]  ad_os,
  output logic        ad_cs,
  output logic        ad_rd,
  output logic        ad_reset,
  output logic        ad_convstab,
  output logic [15:0] smp_data,
  output logic [2:0]  smp_ch,
  output logic        smp_valid,
  output logic        frame_done,
  output logic        overrun,
  output logic        err_tmo,
  output logic        err_sync
);

  localparam int CNT_W  = $clog2(RST_CYC + CONV_LOW + RD_LOW + RD_HIGH + BUSY_TMO + 1);
  localparam int PCNT_W = $clog2(PERIOD + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_CONV, S_WB_HI, S_WB_LO, S_RD_L, S_RD_H, S_WAIT
  } state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [PCNT_W-1:0]   pcnt;
  logic [2:0]          ch, ch_nxt;
  logic                cs_nxt, cap, valid_nxt, fd_nxt, ov_nxt, tmo_set, sync_set;
  logic                pcnt_full, sync_bad;

  assign pcnt_full = (pcnt == PCNT_W'(PERIOD - 1));

`ifdef AD7606_FRSTDATA_CHK_EN
  assign sync_bad = (first_data != (ch == 3'd0));
`else
  logic unused_first_data;
  assign unused_first_data = first_data;
  assign sync_bad          = 1'b0;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt = state;
    ch_nxt    = ch;
    cs_nxt    = ad_cs;
    cap       = 1'b0;
    valid_nxt = 1'b0;
    fd_nxt    = 1'b0;
    ov_nxt    = 1'b0;
    tmo_set   = 1'b0;
    sync_set  = 1'b0;
    case (state)
      S_IDLE: if (enable) state_nxt = S_RST;
      S_RST:  if (cnt == CNT_W'(RST_CYC - 1)) state_nxt = S_CONV;
      S_CONV: if (cnt == CNT_W'(CONV_LOW - 1)) state_nxt = S_WB_HI;
      S_WB_HI: begin
        if (ad_busy) begin
          state_nxt = S_WB_LO;
        end else if (cnt == CNT_W'(BUSY_TMO - 1)) begin
          tmo_set   = 1'b1;
          state_nxt = S_RST;
        end
      end
      S_WB_LO: begin
        if (!ad_busy) begin
          cs_nxt    = 1'b0;
          ch_nxt    = 3'd0;
          state_nxt = S_RD_L;
        end else if (cnt == CNT_W'(BUSY_TMO - 1)) begin
          tmo_set   = 1'b1;
          state_nxt = S_RST;
        end
      end
      S_RD_L: begin
        if (cnt == CNT_W'(RD_LOW - 1)) begin
          if (sync_bad) begin
            sync_set  = 1'b1;
            cs_nxt    = 1'b1;
            state_nxt = S_RST;
          end else begin
            cap       = 1'b1;
            valid_nxt = 1'b1;
            state_nxt = S_RD_H;
          end
        end
      end
      S_RD_H: begin
        if (cnt == CNT_W'(RD_HIGH - 1)) begin
          if (ch == 3'(NCH - 1)) begin
            cs_nxt    = 1'b1;
            fd_nxt    = 1'b1;
            ov_nxt    = pcnt_full;
            state_nxt = S_WAIT;
          end else begin
            ch_nxt    = ch + 3'd1;
            state_nxt = S_RD_L;
          end
        end
      end
      // An overrun frame arrives here with pcnt already saturated and leaves next clock.
      S_WAIT: if (pcnt_full) state_nxt = enable ? S_CONV : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cnt         <= '0;
      pcnt        <= '0;
      ch          <= 3'd0;
      ad_os       <= 3'd0;
      ad_cs       <= 1'b1;
      ad_rd       <= 1'b1;
      ad_reset    <= 1'b0;
      ad_convstab <= 1'b1;
      smp_data    <= 16'd0;
      smp_ch      <= 3'd0;
      smp_valid   <= 1'b0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      err_tmo     <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? '0 : cnt + CNT_W'(1);
      if (state_nxt == S_CONV && state != S_CONV) pcnt <= '0;
      else if (!pcnt_full)                        pcnt <= pcnt + PCNT_W'(1);
      ch    <= ch_nxt;
      ad_cs <= cs_nxt;
      // NOTE: pin strobes decode state_nxt into flops so the ADC sees glitch-free edges.
      ad_rd       <= (state_nxt != S_RD_L);
      ad_convstab <= (state_nxt != S_CONV);
      ad_reset    <= (state_nxt == S_RST);
      if (state == S_IDLE) ad_os <= os_cfg;
      if (cap) begin
        smp_data <= ad_data;
        smp_ch   <= ch;
      end
      smp_valid  <= valid_nxt;
      frame_done <= fd_nxt;
      overrun    <= ov_nxt;
      if (tmo_set) err_tmo <= 1'b1;
    end
  end

`ifdef AD7606_FRSTDATA_CHK_EN
  always_ff @(posedge clk) begin
    if (!rst_n)        err_sync <= 1'b0;
    else if (sync_set) err_sync <= 1'b1;
  end
`else
  logic unused_sync_set;
  assign unused_sync_set = sync_set;
  assign err_sync        = 1'b0;
`endif

endmodule

// File: tb/tb_ad7606_seq_ctrl.sv
// Directed bench for ad7606_seq_ctrl: a default instance plus a short-period instance for overrun.
module tb_ad7606_seq_ctrl;

  localparam int BUSY_LEN  = 200;
  localparam int BUSY_LEN2 = 290;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Main instance
  logic        rst_n = 1'b0, enable = 1'b0;
  logic [2:0]  os_cfg = 3'd5;
  logic [15:0] ad_data = 16'h0;
  logic        ad_busy = 1'b0, first_data = 1'b0;
  logic [2:0]  ad_os, smp_ch;
  logic        ad_cs, ad_rd, ad_reset, ad_convstab, smp_valid, frame_done, overrun, err_tmo, err_sync;
  logic [15:0] smp_data;

  ad7606_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .os_cfg(os_cfg), .ad_data(ad_data),
    .ad_busy(ad_busy), .first_data(first_data), .ad_os(ad_os), .ad_cs(ad_cs), .ad_rd(ad_rd),
    .ad_reset(ad_reset), .ad_convstab(ad_convstab), .smp_data(smp_data), .smp_ch(smp_ch),
    .smp_valid(smp_valid), .frame_done(frame_done), .overrun(overrun), .err_tmo(err_tmo),
    .err_sync(err_sync)
  );

  // Short-period instance
  logic        rst2_n = 1'b0, en2 = 1'b0;
  logic [15:0] ad_data2 = 16'h1234;
  logic        ad_busy2 = 1'b0, first_data2 = 1'b0;
  logic [2:0]  os2, ch2;
  logic        cs2, rd2, rsto2, cv2, v2, fd2, ov2, tmo2, sync2;
  logic [15:0] data2;

  ad7606_seq_ctrl #(.PERIOD(300)) dut_ovr (
    .clk(clk), .rst_n(rst2_n), .enable(en2), .os_cfg(3'd0), .ad_data(ad_data2),
    .ad_busy(ad_busy2), .first_data(first_data2), .ad_os(os2), .ad_cs(cs2), .ad_rd(rd2),
    .ad_reset(rsto2), .ad_convstab(cv2), .smp_data(data2), .smp_ch(ch2),
    .smp_valid(v2), .frame_done(fd2), .overrun(ov2), .err_tmo(tmo2), .err_sync(sync2)
  );

  // Monitors and ADC models, all evaluated on the falling edge
  int          ncyc = 0;
  int          cv_falls[$];
  logic [18:0] sv_q[$];
  int          cv_run = 0, cv_low_w = 0, rst_run = 0, rst_w = 0, rst_pulses = 0;
  int          fd_cnt = 0, ov_cnt = 0, tmo_cyc = 0, cs_low = 0;
  int          idx = 0, busy_cnt = 0;
  logic        prev_cv = 1'b1, prev_rd = 1'b1, prev_tmo = 1'b0;
  logic        busy_en = 1'b1, fd_bad = 1'b0;

  int          idx2 = 0, busy2_cnt = 0, fd2_cnt = 0, ov2_cnt = 0;
  int          last_fd2 = 0, gap2 = 0, cv2_last = 0, cv2_space = 0;
  logic        prev2_cv = 1'b1, prev2_rd = 1'b1;

  always @(negedge clk) begin
    ncyc++;
    if (prev_cv && !ad_convstab) begin
      cv_falls.push_back(ncyc);
      if (busy_en) busy_cnt = BUSY_LEN;
    end
    if (!ad_convstab) cv_run++;
    else begin
      if (cv_run != 0) cv_low_w = cv_run;
      cv_run = 0;
    end
    if (ad_reset) rst_run++;
    else begin
      if (rst_run != 0) begin
        rst_w = rst_run;
        rst_pulses++;
      end
      rst_run = 0;
    end
    if (smp_valid) sv_q.push_back({smp_ch, smp_data});
    if (frame_done) fd_cnt++;
    if (overrun) ov_cnt++;
    if (!prev_tmo && err_tmo) tmo_cyc = ncyc;
    if (!ad_cs) cs_low++;
    if (ad_cs) idx = 0;
    else if (!prev_rd && ad_rd) idx++;
    if (busy_cnt > 0) begin
      ad_busy = 1'b1;
      busy_cnt--;
    end else ad_busy = 1'b0;
    ad_data    = (idx < 4) ? 16'hFFFF : 16'h0FFF;
    first_data = !fd_bad && (idx == 0);
    prev_cv    = ad_convstab;
    prev_rd    = ad_rd;
    prev_tmo   = err_tmo;

    if (prev2_cv && !cv2) begin
      if (cv2_last != 0) cv2_space = ncyc - cv2_last;
      cv2_last  = ncyc;
      gap2      = ncyc - last_fd2;
      busy2_cnt = BUSY_LEN2;
    end
    if (fd2) begin
      fd2_cnt++;
      last_fd2 = ncyc;
    end
    if (ov2) ov2_cnt++;
    if (cs2) idx2 = 0;
    else if (!prev2_rd && rd2) idx2++;
    if (busy2_cnt > 0) begin
      ad_busy2 = 1'b1;
      busy2_cnt--;
    end else ad_busy2 = 1'b0;
    first_data2 = (idx2 == 0);
    prev2_cv    = cv2;
    prev2_rd    = rd2;
  end

  initial begin
    int base, cs0, v0, fdc0, rp0, cvn0;

    // Reset state
    step(3);
    check("reset_pins", {29'd0, ad_cs, ad_rd, ad_convstab}, 32'h7);
    check("reset_strobes", {ad_reset, ad_os, smp_valid, frame_done, overrun, err_tmo, err_sync}, 32'h0);
    check("reset_smp", {smp_ch, smp_data}, 32'h0);

    // ad_os follows os_cfg while idle
    rst_n = 1'b1;
    step(2);
    check("os_idle", ad_os, 32'd5);
    enable = 1'b1;
    step(1);
    os_cfg = 3'd2;

    // Three back-to-back frames
    for (int k = 0; k < 10000 && fd_cnt < 3; k++) step();
    check("wait_3_frames", fd_cnt >= 3, 1);
    check("valid_count", sv_q.size(), 24);
    for (int i = 0; i < 24 && i < sv_q.size(); i++)
      check($sformatf("sample_%0d", i), sv_q[i], {3'(i % 8), ((i % 8) < 4) ? 16'hFFFF : 16'h0FFF});
    check("conv_period_1", cv_falls[1] - cv_falls[0], 2500);
    check("conv_period_2", cv_falls[2] - cv_falls[1], 2500);
    check("conv_low_width", cv_low_w, 2);
    check("no_overrun", ov_cnt, 0);
    check("reset_width", rst_w, 5);
    check("os_held", ad_os, 32'd5);
    check("no_tmo", err_tmo, 0);

    // Dropping enable mid-frame finishes that frame, then idles
    for (int k = 0; k < 3000 && cv_falls.size() < 4; k++) step();
    step(50);
    enable = 1'b0;
    for (int k = 0; k < 3000 && fd_cnt < 4; k++) step();
    step(3000);
    check("stop_frame_done", fd_cnt, 4);
    check("stop_valid", sv_q.size(), 32);
    check("stop_no_conv", cv_falls.size(), 4);
    check("stop_cs_high", ad_cs, 1);

    // BUSY never rises: timeout, 5-clock reset, restart
    busy_en = 1'b0;
    base    = cv_falls.size();
    cs0     = cs_low;
    enable  = 1'b1;
    for (int k = 0; k < 3000 && err_tmo !== 1'b1; k++) step();
    check("tmo_set", err_tmo, 1);
    for (int k = 0; k < 3000 && cv_falls.size() < base + 2; k++) step();
    check("tmo_latency", tmo_cyc - cv_falls[base], 1002);
    check("tmo_restart", cv_falls[base + 1] - tmo_cyc, 5);
    check("tmo_reset_width", rst_w, 5);
    check("tmo_cs_untouched", cs_low - cs0, 0);
    check("tmo_sticky", err_tmo, 1);

    // Reset during the RD low phase of channel 3
    rst_n   = 1'b0;
    busy_en = 1'b1;
    step(2);
    check("rst_clears_tmo", err_tmo, 0);
    v0     = sv_q.size();
    rst_n  = 1'b1;
    for (int k = 0; k < 3000 && !(idx == 3 && ad_rd == 1'b0); k++) step();
    check("reach_rd_ch3", {idx[2:0], ad_rd}, {3'd3, 1'b0});
    rst_n = 1'b0;
    step(1);
    check("midrst_pins", {ad_cs, ad_rd, ad_convstab, ad_reset, smp_valid}, 32'h1C);
    rp0    = rst_pulses;
    cvn0   = cv_falls.size();
    enable = 1'b0;
    step(20);
    rst_n = 1'b1;
    step(500);
    check("midrst_valid", sv_q.size() - v0, 3);
    check("midrst_idle_conv", cv_falls.size() - cvn0, 0);
    check("midrst_idle_reset", rst_pulses - rp0, 0);

    // FRSTDATA held low at channel 0
    fd_bad = 1'b1;
    v0     = sv_q.size();
    fdc0   = fd_cnt;
    rp0    = rst_pulses;
    enable = 1'b1;
`ifdef AD7606_FRSTDATA_CHK_EN
    step(1000);
    check("sync_err", err_sync, 1);
    check("sync_no_valid", sv_q.size() - v0, 0);
    check("sync_no_frame", fd_cnt - fdc0, 0);
    check("sync_reset_again", (rst_pulses - rp0) >= 2, 1);
`else
    for (int k = 0; k < 3000 && fd_cnt < fdc0 + 1; k++) step();
    check("nochk_frame", fd_cnt - fdc0, 1);
    check("nochk_valid", sv_q.size() - v0, 8);
    check("nochk_err_sync", err_sync, 0);
`endif
    enable = 1'b0;

    // Short-period instance: every frame overruns
    rst2_n = 1'b1;
    en2    = 1'b1;
    for (int k = 0; k < 2000 && fd2_cnt < 3; k++) step();
    check("ovr_frames", fd2_cnt >= 3, 1);
    check("ovr_pulses", ov2_cnt, fd2_cnt);
    step(5);
    check("ovr_conv_gap", gap2, 1);
    check("ovr_stretched", cv2_space > 300, 1);
    check("ovr_no_tmo", tmo2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
